// File: rtl/line_buffer_read_ctrl.sv
// Read-side controller for the three-bank camera line buffer, VGA_CLK domain only.
// Define LINE_READ_MIRROR_EN to emit descending READ_Cont addresses (horizontal mirror).
module line_buffer_read_ctrl #(
  parameter int unsigned H_START  = 144,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_START  = 35,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic        VGA_CLK,
  input  logic        RESET,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic [1:0]  WR,
  output logic        READ_Request,
  output logic [12:0] READ_Cont,
  output logic [12:0] V_Cont,
  output logic        READ_VALID,
  output logic [1:0]  LINES_AVAIL,
  output logic        UNDERRUN
);

  localparam int unsigned CW = 13;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] H_FIRST = CW'(H_START);
  localparam logic [CW-1:0] H_LAST  = CW'(H_START + H_ACTIVE - 1);
  localparam logic [CW-1:0] V_FIRST = CW'(V_START);
  localparam logic [CW-1:0] V_LAST  = CW'(V_START + V_ACTIVE - 1);
  localparam logic [CW-1:0] H_SPAN  = CW'(H_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, FILL, STREAM} state_t;

  state_t          r_state;
  logic [1:0]      r_wr_s1, r_wr_s2, r_wr_prev;
  logic            r_hs_d, r_vs_d;
  logic [CW-1:0]   r_h_cnt, r_v_cnt;
  logic [1:0]      r_avail;
  logic            r_line_ok;
  logic            r_read_req;
  logic [CW-1:0]   r_read_cont;
  logic            r_underrun;
  logic [RD_LAT-1:0] r_valid_sr;

  logic            w_hs_fall, w_vs_fall, w_line_evt, w_eol, w_avail_ge2;
  logic [CW-1:0]   w_h_nxt, w_v_nxt, w_h_off, w_rd_addr;
  logic            w_h_nxt_act, w_v_act, w_v_nxt_act, w_rd_nxt;
  logic [1:0]      w_avail_nxt;

  assign w_hs_fall   = r_hs_d & ~VGA_HS;
  assign w_vs_fall   = r_vs_d & ~VGA_VS;
  assign w_line_evt  = (r_wr_s2 != r_wr_prev);
  assign w_avail_ge2 = (r_avail >= 2'd2);

  // Next counter values; the read window is registered from these so it lines up with H_Cont.
  assign w_h_nxt = w_hs_fall ? '0 : ((r_h_cnt == CNT_MAX) ? r_h_cnt : r_h_cnt + CW'(1));
  assign w_v_nxt = w_vs_fall ? '0 :
                   (w_hs_fall ? ((r_v_cnt == CNT_MAX) ? r_v_cnt : r_v_cnt + CW'(1)) : r_v_cnt);

  assign w_h_nxt_act = (w_h_nxt >= H_FIRST) && (w_h_nxt <= H_LAST);
  assign w_v_act     = (r_v_cnt >= V_FIRST) && (r_v_cnt <= V_LAST);
  assign w_v_nxt_act = (w_v_nxt >= V_FIRST) && (w_v_nxt <= V_LAST);

  assign w_rd_nxt = (r_state == STREAM) && w_v_act && w_h_nxt_act && r_line_ok;
  assign w_h_off  = w_h_nxt - H_FIRST;
`ifdef LINE_READ_MIRROR_EN
  assign w_rd_addr = H_SPAN - w_h_off;
`else
  assign w_rd_addr = w_h_off;
`endif

  // Last pixel of a line that was actually read consumes one buffered line.
  assign w_eol = r_read_req && (r_h_cnt == H_LAST);

  always_comb begin
    w_avail_nxt = r_avail;
    if (w_line_evt && !w_eol) begin
      if (r_avail != 2'd3) w_avail_nxt = r_avail + 2'd1;
    end else if (w_eol && !w_line_evt) begin
      if (r_avail != 2'd0) w_avail_nxt = r_avail - 2'd1;
    end
  end

  // Synchronisers, sync edge detectors and timing counters.
  always_ff @(posedge VGA_CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_s1   <= 2'd0;
      r_wr_s2   <= 2'd0;
      r_wr_prev <= 2'd0;
      r_hs_d    <= 1'b0;
      r_vs_d    <= 1'b0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_avail   <= 2'd0;
    end else begin
      r_wr_s1   <= WR;
      r_wr_s2   <= r_wr_s1;
      r_wr_prev <= r_wr_s2;
      r_hs_d    <= VGA_HS;
      r_vs_d    <= VGA_VS;
      r_h_cnt   <= w_h_nxt;
      r_v_cnt   <= w_v_nxt;
      r_avail   <= w_avail_nxt;
    end
  end

  // Frame FSM with its registered outputs.
  always_ff @(posedge VGA_CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_line_ok   <= 1'b0;
      r_read_req  <= 1'b0;
      r_read_cont <= '0;
      r_underrun  <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    r_state <= WAIT_VS;
        WAIT_VS: if (w_vs_fall) r_state <= FILL;
        FILL:    if (!w_vs_fall && w_hs_fall && w_avail_ge2) r_state <= STREAM;
        STREAM:  if (w_vs_fall) r_state <= FILL;
        default: r_state <= IDLE;
      endcase

      if (w_hs_fall) r_line_ok <= w_avail_ge2;

      r_read_req  <= w_rd_nxt;
      r_read_cont <= w_rd_nxt ? w_rd_addr : '0;

      if (w_vs_fall)
        r_underrun <= 1'b0;
      else if (w_hs_fall && (r_state == STREAM) && w_v_nxt_act && !w_avail_ge2)
        r_underrun <= 1'b1;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) r_valid_sr <= '0;
        else       r_valid_sr <= r_read_req;
      end
    end else begin : g_latn
      always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) r_valid_sr <= '0;
        else       r_valid_sr <= {r_valid_sr[RD_LAT-2:0], r_read_req};
      end
    end
  endgenerate

  assign READ_Request = r_read_req;
  assign READ_Cont    = r_read_cont;
  assign V_Cont       = r_v_cnt;
  assign READ_VALID   = r_valid_sr[RD_LAT-1];
  assign LINES_AVAIL  = r_avail;
  assign UNDERRUN     = r_underrun;

endmodule

// File: tb/tb_line_buffer_read_ctrl.sv
// Scoreboard bench for line_buffer_read_ctrl: stimulus queues expected reads, a monitor pops them.
// Honours LINE_READ_MIRROR_EN for the expected address order.
module tb_line_buffer_read_ctrl;

  logic        VGA_CLK = 1'b0;
  logic        RESET   = 1'b1;
  logic        VGA_HS  = 1'b1;
  logic        VGA_VS  = 1'b1;
  logic [1:0]  WR      = 2'd0;
  logic        READ_Request;
  logic [12:0] READ_Cont;
  logic [12:0] V_Cont;
  logic        READ_VALID;
  logic [1:0]  LINES_AVAIL;
  logic        UNDERRUN;

  line_buffer_read_ctrl dut (
    .VGA_CLK     (VGA_CLK),
    .RESET       (RESET),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .WR          (WR),
    .READ_Request(READ_Request),
    .READ_Cont   (READ_Cont),
    .V_Cont      (V_Cont),
    .READ_VALID  (READ_VALID),
    .LINES_AVAIL (LINES_AVAIL),
    .UNDERRUN    (UNDERRUN)
  );

  always #20 VGA_CLK = ~VGA_CLK;

  typedef struct {
    int cyc;
    int addr;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic prev_req = 1'b0;

  always @(posedge VGA_CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_addr(input int i);
`ifdef LINE_READ_MIRROR_EN
    return 639 - i;
`else
    return i;
`endif
  endfunction

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One HS period of len cycles; optionally expects a read and changes WR at offset wr_at.
  task automatic do_line(input int len, input bit exp_rd, input int wr_at, input logic [1:0] wr_val);
    int n;
    int hs_low;
    hs_low = (len > 200) ? 96 : 1;
    tick();
    VGA_HS = 1'b0;
    n = cyc;
    if (exp_rd)
      for (int i = 0; i < 640; i++) exp_q.push_back('{cyc: n + 145 + i, addr: exp_addr(i)});
    for (int k = 1; k < len; k++) begin
      tick();
      if (k == hs_low) VGA_HS = 1'b1;
      if (k == wr_at) WR = wr_val;
    end
  endtask

  task automatic short_lines(input int n);
    for (int i = 0; i < n; i++) do_line(5, 1'b0, -1, 2'd0);
  endtask

  task automatic vsync();
    tick();
    VGA_VS = 1'b0;
    tick();
    VGA_VS = 1'b1;
    ticks(2);
  endtask

  task automatic set_wr(input logic [1:0] v, input int hold);
    WR = v;
    ticks(hold);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read_request"}, int'(READ_Request), 0);
    chk({tag, "_read_cont"},    int'(READ_Cont), 0);
    chk({tag, "_v_cont"},       int'(V_Cont), 0);
    chk({tag, "_read_valid"},   int'(READ_VALID), 0);
    chk({tag, "_lines_avail"},  int'(LINES_AVAIL), 0);
    chk({tag, "_underrun"},     int'(UNDERRUN), 0);
  endtask

  // Monitor: READ_VALID lag, READ_Cont idle value, and every read against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge VGA_CLK);
      if (RESET) begin
        prev_req = 1'b0;
      end else begin
        chk("read_valid_lag", int'(READ_VALID), int'(prev_req));
        if (READ_Request) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_read: READ_Cont=%0d V_Cont=%0d at cycle %0d, none expected",
                     READ_Cont, V_Cont, cyc);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (cyc != e.cyc || int'(READ_Cont) != e.addr) begin
              failures++;
              $display("FAIL read_beat: got cycle %0d addr %0d expected cycle %0d addr %0d",
                       cyc, READ_Cont, e.cyc, e.addr);
            end
          end
        end else if (prev_req) begin
          chk("read_cont_idle", int'(READ_Cont), 0);
        end
        prev_req = READ_Request;
      end
    end
  end

  initial begin
    // Reset state
    ticks(4);
    chk_all_zero("reset");
    RESET = 1'b0;
    ticks(3);

    // Fill: two line-complete events, then first active line streams
    vsync();
    chk("fill_v_cont_cleared", int'(V_Cont), 0);
    set_wr(2'd1, 6);
    set_wr(2'd2, 6);
    chk("fill_avail_2", int'(LINES_AVAIL), 2);
    short_lines(34);
    chk("fill_v_cont_34", int'(V_Cont), 34);
    do_line(800, 1'b1, -1, 2'd0);
    chk("stream_v_cont_35", int'(V_Cont), 35);
    chk("stream_avail_after_read", int'(LINES_AVAIL), 1);
    chk("stream_no_underrun", int'(UNDERRUN), 0);

    // Underrun: only one line available at the next active line
    do_line(800, 1'b0, -1, 2'd0);
    chk("underrun_set", int'(UNDERRUN), 1);
    chk("underrun_avail_kept", int'(LINES_AVAIL), 1);
    vsync();
    chk("underrun_cleared_by_vs", int'(UNDERRUN), 0);
    chk("vs_avail_kept", int'(LINES_AVAIL), 1);

    // Wrap 2->0 held gives exactly one event; then saturate at 3
    set_wr(2'd0, 10);
    chk("wrap_single_event", int'(LINES_AVAIL), 2);
    set_wr(2'd1, 6);
    set_wr(2'd2, 6);
    set_wr(2'd0, 6);
    chk("avail_saturated", int'(LINES_AVAIL), 3);
    short_lines(34);
    // WR change lands on the same edge as the end-of-line decrement
    do_line(800, 1'b1, 782, 2'd1);
    chk("sat_simultaneous_stays_3", int'(LINES_AVAIL), 3);
    do_line(800, 1'b1, -1, 2'd0);
    chk("sat_decrement_to_2", int'(LINES_AVAIL), 2);
    do_line(800, 1'b1, -1, 2'd0);
    chk("decrement_to_1", int'(LINES_AVAIL), 1);
    chk("sat_no_underrun", int'(UNDERRUN), 0);
    set_wr(2'd2, 6);
    chk("refill_avail_2", int'(LINES_AVAIL), 2);

    // Reset asserted mid-line while reading
    do_line(300, 1'b1, -1, 2'd0);
    chk("midline_reading", int'(READ_Request), 1);
    RESET = 1'b1;
    WR = 2'd0;
    #1;
    chk_all_zero("midline_reset");
    exp_q.delete();
    ticks(4);
    RESET = 1'b0;
    ticks(3);

    // No read without a fresh VS edge, even on an active line
    short_lines(34);
    do_line(800, 1'b0, -1, 2'd0);
    chk("post_reset_v_cont_35", int'(V_Cont), 35);
    chk("post_reset_avail_0", int'(LINES_AVAIL), 0);
    chk("post_reset_no_underrun", int'(UNDERRUN), 0);

    // Recovery: VS edge, two events, stream again
    vsync();
    set_wr(2'd1, 6);
    set_wr(2'd2, 6);
    chk("recover_avail_2", int'(LINES_AVAIL), 2);
    short_lines(34);
    do_line(800, 1'b1, -1, 2'd0);
    chk("recover_avail_1", int'(LINES_AVAIL), 1);
    ticks(5);

    chk("exp_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
